csi_packet_parser: RTL and testbench

- Sits directly downstream of the lane word aligner in the CSI receiver.
- Consumes aligned 16-bit words from the 2-lane stream. Parses CSI-2 packet headers, strips the header and CRC trailer, and emits long-packet payload as an AXI4-Stream master with correct tstrb, tlast and start-of-frame tuser.
- Short packets (frame/line start/end) produce status pulses only.
- A small FIFO absorbs downstream backpressure, because the D-PHY cannot be stalled.

---
 rtl/csi_packet_parser_pkg.sv | 45 ++++
 rtl/csi_packet_parser_if.sv | 21 ++
 rtl/csi_packet_parser_sync_fifo.sv | 53 +++++
 rtl/csi_packet_parser.sv | 230 +++++++++++++++++++++++
 tb/tb_csi_packet_parser.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/csi_packet_parser_pkg.sv
// Shared types for the CSI-2 packet parser: data-type codes, parser states, FIFO beat layout
// and the CSI-2 header ECC function.
package csirx_pkg;

    localparam logic [5:0] DT_FRAME_START = 6'h00;
    localparam logic [5:0] DT_FRAME_END   = 6'h01;
    localparam logic [5:0] DT_LINE_START  = 6'h02;
    localparam logic [5:0] DT_LINE_END    = 6'h03;
    localparam logic [5:0] DT_LONG_MIN    = 6'h10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_PAYLOAD,
        ST_CRC,
        ST_SKIP
    } parser_state_e;

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [1:0]  tstrb;
        logic [15:0] tdata;
    } axis_beat_t;

    // Each mask selects the header bits {WC[15:8], WC[7:0], DI} covered by one parity bit.
    localparam logic [23:0] ECC_MASK_P0 = 24'hF12CB7;
    localparam logic [23:0] ECC_MASK_P1 = 24'hF2555B;
    localparam logic [23:0] ECC_MASK_P2 = 24'h749A6D;
    localparam logic [23:0] ECC_MASK_P3 = 24'hB8E38E;
    localparam logic [23:0] ECC_MASK_P4 = 24'hDF03F0;
    localparam logic [23:0] ECC_MASK_P5 = 24'hEFFC00;

    function automatic logic [5:0] csi_ecc24(input logic [23:0] hdr);
        logic [5:0] ecc;
        ecc[0] = ^(hdr & ECC_MASK_P0);
        ecc[1] = ^(hdr & ECC_MASK_P1);
        ecc[2] = ^(hdr & ECC_MASK_P2);
        ecc[3] = ^(hdr & ECC_MASK_P3);
        ecc[4] = ^(hdr & ECC_MASK_P4);
        ecc[5] = ^(hdr & ECC_MASK_P5);
        return ecc;
    endfunction

endpackage

// File: rtl/csi_packet_parser_if.sv
// AXI4-Stream payload bus leaving the CSI packet parser.
interface csi_packet_parser_if #(
    parameter int WORD_W = 16
);
    logic                  tvalid;
    logic [WORD_W-1:0]     tdata;
    logic [WORD_W/8-1:0]   tstrb;
    logic                  tlast;
    logic                  tuser;
    logic                  tready;

    modport master (
        output tvalid, tdata, tstrb, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/csi_packet_parser_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; output reads zero while empty.
// A write while full is accepted only if a read happens in the same cycle.
module csi_sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_ok;
    logic             rd_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_ok   = rd_en_i && !empty_o;
    assign wr_ok   = wr_en_i && (!full_o || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/csi_packet_parser.sv
// CSI-2 packet parser: strips header/CRC from 2-lane words and streams long-packet payload.
// Define CSI_ECC_CHECK_EN to reject headers whose ECC byte does not match.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | waiting for the first header word of a burst
// ST_HDR1    | word0 latched, decoding word1 (WC high byte, ECC)
// ST_PAYLOAD | pushing one payload beat per word
// ST_CRC     | discarding the CRC trailer word
// ST_SKIP    | ignoring words until the burst ends
module csi_packet_parser
    import csirx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int WORD_W     = 16
) (
    input  logic              rxbyteclkhs,
    input  logic              rxbyteclkhs_reset,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    csi_packet_parser_if.master m_axis,
    output logic [1:0]        pkt_vc,
    output logic [5:0]        pkt_dt,
    output logic              frame_start,
    output logic              frame_end,
    output logic              truncated,
    output logic              overflow,
    output logic              ecc_error
);
    localparam int BEAT_W = $bits(axis_beat_t);

    parser_state_e state_q, state_d;
    logic [7:0]    di_q, di_d;
    logic [7:0]    wc_lo_q, wc_lo_d;
    logic [15:0]   remaining_q, remaining_d;
    logic          sof_q, sof_d;
    logic          first_q, first_d;
    logic [1:0]    vc_q, vc_d;
    logic [5:0]    dt_q, dt_d;
    logic          fs_q, fs_d;
    logic          fe_q, fe_d;
    logic          trunc_q, trunc_d;
    logic          overflow_q, overflow_d;

    logic          hdr_ok;
    logic [15:0]   hdr_wc;
    logic [5:0]    hdr_dt;
    logic          push;
    axis_beat_t    push_beat;
    axis_beat_t    pop_beat;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign hdr_wc = {word_in[7:0], wc_lo_q};
    assign hdr_dt = di_q[5:0];

`ifdef CSI_ECC_CHECK_EN
    logic ecc_err_q, ecc_err_d;
    assign hdr_ok = (word_in[15:14] == 2'b00) &&
                    (csi_ecc24({word_in[7:0], wc_lo_q, di_q}) == word_in[13:8]);
    assign ecc_error = ecc_err_q;
`else
    assign hdr_ok    = 1'b1;
    assign ecc_error = 1'b0;
`endif

    assign pop = !fifo_empty && m_axis.tready;

    always_comb begin
        state_d     = state_q;
        di_d        = di_q;
        wc_lo_d     = wc_lo_q;
        remaining_d = remaining_q;
        sof_d       = sof_q;
        first_d     = first_q;
        vc_d        = vc_q;
        dt_d        = dt_q;
        fs_d        = 1'b0;
        fe_d        = 1'b0;
        trunc_d     = 1'b0;
        overflow_d  = overflow_q;
        push        = 1'b0;
        push_beat   = '0;
`ifdef CSI_ECC_CHECK_EN
        ecc_err_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (word_valid) begin
                    di_d    = word_in[7:0];
                    wc_lo_d = word_in[15:8];
                    state_d = ST_HDR1;
                end
            end

            ST_HDR1: begin
                if (!word_valid) begin
                    trunc_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (!hdr_ok) begin
`ifdef CSI_ECC_CHECK_EN
                    ecc_err_d = 1'b1;
`endif
                    state_d = ST_SKIP;
                end else begin
                    vc_d = di_q[7:6];
                    dt_d = hdr_dt;
                    if (hdr_dt < DT_LONG_MIN) begin
                        if (hdr_dt == DT_FRAME_START) begin
                            fs_d  = 1'b1;
                            sof_d = 1'b1;
                        end else if (hdr_dt == DT_FRAME_END) begin
                            fe_d = 1'b1;
                        end
                        state_d = ST_SKIP;
                    end else if (hdr_wc == 16'd0) begin
                        state_d = ST_CRC;
                    end else begin
                        remaining_d = hdr_wc;
                        first_d     = 1'b1;
                        state_d     = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                push    = 1'b1;
                first_d = 1'b0;
                if (!word_valid) begin
                    // Terminator beat lets downstream close the packet cleanly.
                    trunc_d         = 1'b1;
                    push_beat.tlast = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    push_beat.tuser = sof_q && first_q;
                    if (first_q) sof_d = 1'b0;
                    if (remaining_q >= 16'd2) begin
                        push_beat.tstrb = 2'b11;
                        push_beat.tdata = word_in;
                        remaining_d     = remaining_q - 16'd2;
                    end else begin
                        push_beat.tstrb = 2'b01;
                        push_beat.tdata = {8'h00, word_in[7:0]};
                        remaining_d     = 16'd0;
                    end
                    push_beat.tlast = (remaining_q <= 16'd2);
                    if (remaining_q <= 16'd2) state_d = ST_CRC;
                end
            end

            ST_CRC: begin
                state_d = word_valid ? ST_SKIP : ST_IDLE;
            end

            ST_SKIP: begin
                if (!word_valid) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        if (push && fifo_full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge rxbyteclkhs) begin
        if (rxbyteclkhs_reset) begin
            state_q     <= ST_IDLE;
            di_q        <= '0;
            wc_lo_q     <= '0;
            remaining_q <= '0;
            sof_q       <= 1'b0;
            first_q     <= 1'b0;
            vc_q        <= '0;
            dt_q        <= '0;
            fs_q        <= 1'b0;
            fe_q        <= 1'b0;
            trunc_q     <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef CSI_ECC_CHECK_EN
            ecc_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            di_q        <= di_d;
            wc_lo_q     <= wc_lo_d;
            remaining_q <= remaining_d;
            sof_q       <= sof_d;
            first_q     <= first_d;
            vc_q        <= vc_d;
            dt_q        <= dt_d;
            fs_q        <= fs_d;
            fe_q        <= fe_d;
            trunc_q     <= trunc_d;
            overflow_q  <= overflow_d;
`ifdef CSI_ECC_CHECK_EN
            ecc_err_q   <= ecc_err_d;
`endif
        end
    end

    csi_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (rxbyteclkhs),
        .rst_i     (rxbyteclkhs_reset),
        .wr_en_i   (push),
        .wr_data_i (push_beat),
        .rd_en_i   (pop),
        .rd_data_o (pop_beat),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = pop_beat.tdata;
    assign m_axis.tstrb  = pop_beat.tstrb;
    assign m_axis.tlast  = pop_beat.tlast;
    assign m_axis.tuser  = pop_beat.tuser;

    assign pkt_vc      = vc_q;
    assign pkt_dt      = dt_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;
    assign truncated   = trunc_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_csi_packet_parser.sv
// Directed bench for csi_packet_parser; exercises CSI_ECC_CHECK_EN cases when that macro is set.
module tb_csi_packet_parser;

    logic        clk;
    logic        rst;
    logic [15:0] word_in;
    logic        word_valid;
    logic [1:0]  pkt_vc;
    logic [5:0]  pkt_dt;
    logic        frame_start, frame_end, truncated, overflow, ecc_error;

    csi_packet_parser_if axis_if ();

    csi_packet_parser #(.FIFO_DEPTH(16), .WORD_W(16)) dut (
        .rxbyteclkhs       (clk),
        .rxbyteclkhs_reset (rst),
        .word_in           (word_in),
        .word_valid        (word_valid),
        .m_axis            (axis_if),
        .pkt_vc            (pkt_vc),
        .pkt_dt            (pkt_dt),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .truncated         (truncated),
        .overflow          (overflow),
        .ecc_error         (ecc_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parity-check-matrix columns for header bits D0..D23.
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    int n_tests = 0;
    int n_fail  = 0;
    int fs_cnt  = 0;
    int fe_cnt  = 0;
    int tr_cnt  = 0;
    int ecc_cnt = 0;
    logic [19:0] beats_q [$];

    always @(negedge clk) begin
        if (axis_if.tvalid && axis_if.tready)
            beats_q.push_back({axis_if.tuser, axis_if.tlast, axis_if.tstrb, axis_if.tdata});
        if (frame_start) fs_cnt++;
        if (frame_end)   fe_cnt++;
        if (truncated)   tr_cnt++;
        if (ecc_error)   ecc_cnt++;
    end

    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] e = '0;
        for (int k = 0; k < 24; k++)
            if (d[k]) e = e ^ ECC_COL[k];
        return e;
    endfunction

    function automatic logic [19:0] get_beat(input int idx);
        if (idx < beats_q.size()) return beats_q[idx];
        return 20'hFFFFF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] w, input logic v);
        @(posedge clk);
        #1;
        word_in    = w;
        word_valid = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(16'h0000, 1'b0);
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic bad_ecc);
        logic [5:0] e;
        e = ref_ecc({wc, di}) ^ {5'b0, bad_ecc};
        drive({wc[7:0], di}, 1'b1);
        drive({2'b00, e, wc[15:8]}, 1'b1);
    endtask

    int b0, fs0, fe0, tr0, ecc0;

    initial begin
        rst = 1'b1;
        word_in = '0;
        word_valid = 1'b0;
        axis_if.tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_tvalid", axis_if.tvalid, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_pkt_dt", pkt_dt, 0);
        check_val("rst_pkt_vc", pkt_vc, 0);
        check_val("rst_pulses", {frame_start, frame_end, truncated, ecc_error}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Frame Start, then a 6-byte long packet
        b0 = beats_q.size(); fs0 = fs_cnt;
        send_hdr(8'h00, 16'h0001, 1'b0);
        drive(16'h0000, 1'b0);
        send_hdr(8'h2A, 16'd6, 1'b0);
        drive(16'h0201, 1'b1);
        @(negedge clk);
        check_val("lat_same_cycle", axis_if.tvalid, 0);
        drive(16'h0403, 1'b1);
        @(negedge clk);
        check_val("lat_next_cycle", axis_if.tvalid, 1);
        drive(16'h0605, 1'b1);
        drive(16'hBEEF, 1'b1);
        idle(4);
        check_val("t1_fs_pulses", fs_cnt - fs0, 1);
        check_val("t1_nbeats", beats_q.size() - b0, 3);
        check_val("t1_beat0", get_beat(b0),     {1'b1, 1'b0, 2'b11, 16'h0201});
        check_val("t1_beat1", get_beat(b0 + 1), {1'b0, 1'b0, 2'b11, 16'h0403});
        check_val("t1_beat2", get_beat(b0 + 2), {1'b0, 1'b1, 2'b11, 16'h0605});
        check_val("t1_pkt_dt", pkt_dt, 6'h2A);
        check_val("t1_pkt_vc", pkt_vc, 0);

        // Odd word count: last beat carries one byte
        b0 = beats_q.size();
        send_hdr(8'h2A, 16'd5, 1'b0);
        drive(16'h0201, 1'b1);
        drive(16'h0403, 1'b1);
        drive(16'hCC05, 1'b1);
        drive(16'h00DD, 1'b1);
        idle(4);
        check_val("t2_nbeats", beats_q.size() - b0, 3);
        check_val("t2_beat0", get_beat(b0),     {1'b0, 1'b0, 2'b11, 16'h0201});
        check_val("t2_beat1", get_beat(b0 + 1), {1'b0, 1'b0, 2'b11, 16'h0403});
        check_val("t2_beat2", get_beat(b0 + 2), {1'b0, 1'b1, 2'b01, 16'h0005});

        // Backpressure: 20 beats into a 16-entry FIFO
        b0 = beats_q.size();
        axis_if.tready = 1'b0;
        send_hdr(8'h2A, 16'd40, 1'b0);
        for (int i = 0; i < 20; i++) drive(16'h1000 + 16'(i), 1'b1);
        drive(16'hC0C0, 1'b1);
        idle(2);
        @(negedge clk);
        check_val("t3_overflow_set", overflow, 1);
        check_val("t3_no_pop_stalled", beats_q.size() - b0, 0);
        @(posedge clk);
        #1 axis_if.tready = 1'b1;
        idle(30);
        check_val("t3_nbeats", beats_q.size() - b0, 16);
        for (int i = 0; i < 16; i++)
            check_val($sformatf("t3_beat%0d", i), get_beat(b0 + i),
                      {1'b0, 1'b0, 2'b11, 16'h1000 + 16'(i)});
        check_val("t3_overflow_sticky", overflow, 1);

        // Burst ends after 2 of 4 payload words
        b0 = beats_q.size(); tr0 = tr_cnt;
        send_hdr(8'h2A, 16'd8, 1'b0);
        drive(16'h1111, 1'b1);
        drive(16'h2222, 1'b1);
        idle(4);
        check_val("t4_trunc_pulse", tr_cnt - tr0, 1);
        check_val("t4_nbeats", beats_q.size() - b0, 3);
        check_val("t4_beat0", get_beat(b0),     {1'b0, 1'b0, 2'b11, 16'h1111});
        check_val("t4_beat1", get_beat(b0 + 1), {1'b0, 1'b0, 2'b11, 16'h2222});
        check_val("t4_term",  get_beat(b0 + 2), {1'b0, 1'b1, 2'b00, 16'h0000});

        // Frame End with corrupted ECC, then with correct ECC
        fe0 = fe_cnt; ecc0 = ecc_cnt;
        send_hdr(8'h01, 16'h0001, 1'b1);
        idle(3);
`ifdef CSI_ECC_CHECK_EN
        check_val("t5_ecc_pulse", ecc_cnt - ecc0, 1);
        check_val("t5_no_fe", fe_cnt - fe0, 0);
        check_val("t5_dt_kept", pkt_dt, 6'h2A);
`else
        check_val("t5_ecc_tied", ecc_cnt - ecc0, 0);
        check_val("t5_fe_ecc_ignored", fe_cnt - fe0, 1);
        check_val("t5_dt_fe", pkt_dt, 6'h01);
`endif
        fe0 = fe_cnt; ecc0 = ecc_cnt;
        send_hdr(8'h01, 16'h0001, 1'b0);
        idle(3);
        check_val("t5_fe_pulse", fe_cnt - fe0, 1);
        check_val("t5_no_ecc", ecc_cnt - ecc0, 0);
        check_val("t5_dt_after", pkt_dt, 6'h01);

        // Reset while 3 beats are queued mid-payload
        axis_if.tready = 1'b0;
        send_hdr(8'h00, 16'h0002, 1'b0);
        drive(16'h0000, 1'b0);
        send_hdr(8'h2A, 16'd10, 1'b0);
        drive(16'hA1A1, 1'b1);
        drive(16'hA2A2, 1'b1);
        drive(16'hA3A3, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        word_in = 16'hA4A4;
        word_valid = 1'b1;
        @(negedge clk);
        check_val("t6_queued_head", {axis_if.tvalid, axis_if.tdata}, {1'b1, 16'hA1A1});
        @(posedge clk);
        #1;
        rst = 1'b0;
        word_valid = 1'b0;
        @(negedge clk);
        check_val("t6_tvalid_cleared", axis_if.tvalid, 0);
        check_val("t6_overflow_cleared", overflow, 0);
        check_val("t6_pkt_dt_cleared", pkt_dt, 0);

        b0 = beats_q.size();
        axis_if.tready = 1'b1;
        idle(2);
        send_hdr(8'h6A, 16'd4, 1'b0);
        drive(16'h3231, 1'b1);
        drive(16'h3433, 1'b1);
        drive(16'h5A5A, 1'b1);
        idle(4);
        check_val("t7_nbeats", beats_q.size() - b0, 2);
        check_val("t7_beat0", get_beat(b0),     {1'b0, 1'b0, 2'b11, 16'h3231});
        check_val("t7_beat1", get_beat(b0 + 1), {1'b0, 1'b1, 2'b11, 16'h3433});
        check_val("t7_pkt_vc", pkt_vc, 2'd1);
        check_val("t7_pkt_dt", pkt_dt, 6'h2A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
